// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes over a 2^WINDOW_LOG2-sample window and emits a scaled intensity on a valid/ready stream.
// Optional inter-spike-interval readout (last_isi) is built when SPIKE_DECODER_ISI_EN is defined.
module spike_rate_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  spike,
    input  logic                  spike_valid,
    input  logic                  rate_ready,
    output logic [DATA_WIDTH-1:0] rate_out,
    output logic                  rate_valid,
    output logic                  overrun,
`ifdef SPIKE_DECODER_ISI_EN
    output logic                  window_busy,
    output logic [15:0]           last_isi
`else
    output logic                  window_busy
`endif
);

    localparam int CW  = WINDOW_LOG2 + 1;
    localparam int SW  = ((DATA_WIDTH > WINDOW_LOG2) ? DATA_WIDTH : WINDOW_LOG2) + 2;
    localparam int SHL = (DATA_WIDTH >= WINDOW_LOG2) ? (DATA_WIDTH - WINDOW_LOG2) : 0;
    localparam int SHR = (DATA_WIDTH >= WINDOW_LOG2) ? 0 : (WINDOW_LOG2 - DATA_WIDTH);
    localparam logic [CW-1:0] WIN_LAST = CW'((1 << WINDOW_LOG2) - 1);
    localparam logic [SW-1:0] RATE_MAX = {{(SW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

    logic [CW-1:0]         sample_cnt_q, sample_cnt_d;
    logic [CW-1:0]         spike_cnt_q, spike_cnt_d;
    logic [CW-1:0]         spike_total;
    logic [SW-1:0]         scaled;
    logic [DATA_WIDTH-1:0] rate_value;
    logic [DATA_WIDTH-1:0] rate_out_q, rate_out_d;
    logic                  overrun_q, overrun_d;
    logic                  sample_take, window_done, load;
    out_state_e            state_q, state_d;

    // Counters return to zero on the completing sample, so the next sample opens a new window.
    always_comb begin
        sample_take  = enable && spike_valid;
        window_done  = sample_take && (sample_cnt_q == WIN_LAST);
        spike_total  = spike_cnt_q + CW'(spike);
        sample_cnt_d = sample_cnt_q;
        spike_cnt_d  = spike_cnt_q;
        if (clear || window_done) begin
            sample_cnt_d = '0;
            spike_cnt_d  = '0;
        end else if (sample_take) begin
            sample_cnt_d = sample_cnt_q + 1'b1;
            spike_cnt_d  = spike_total;
        end
    end

    always_comb begin
        scaled     = (SW'(spike_total) << SHL) >> SHR;
        rate_value = (scaled > RATE_MAX) ? {DATA_WIDTH{1'b1}} : scaled[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= OUT_EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = OUT_EMPTY;
        end else begin
            case (state_q)
                OUT_EMPTY: if (window_done) state_d = OUT_FULL;
                OUT_FULL:  if (!window_done && rate_ready) state_d = OUT_EMPTY;
                default:   state_d = OUT_EMPTY;
            endcase
        end
    end

    // A completion while full only replaces the held value if it is being accepted this cycle.
    always_comb begin
        rate_valid = (state_q == OUT_FULL);
        load       = window_done && !clear && ((state_q == OUT_EMPTY) || rate_ready);
        rate_out_d = clear ? '0 : (load ? rate_value : rate_out_q);
        overrun_d  = !clear && (overrun_q ||
                     (window_done && (state_q == OUT_FULL) && !rate_ready));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            spike_cnt_q  <= '0;
            rate_out_q   <= '0;
            overrun_q    <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            spike_cnt_q  <= spike_cnt_d;
            rate_out_q   <= rate_out_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rate_out    = rate_out_q;
    assign overrun     = overrun_q;
    assign window_busy = (sample_cnt_q != '0);

`ifdef SPIKE_DECODER_ISI_EN
    logic [15:0] isi_cnt_q, isi_cnt_d;
    logic [15:0] last_isi_q, last_isi_d;
    logic [15:0] isi_next;

    // The interval runs across window boundaries; only clear or reset restarts it.
    always_comb begin
        isi_next   = (isi_cnt_q == 16'hFFFF) ? isi_cnt_q : isi_cnt_q + 16'd1;
        isi_cnt_d  = isi_cnt_q;
        last_isi_d = last_isi_q;
        if (clear) begin
            isi_cnt_d  = '0;
            last_isi_d = '0;
        end else if (sample_take) begin
            if (spike) begin
                last_isi_d = isi_next;
                isi_cnt_d  = '0;
            end else begin
                isi_cnt_d  = isi_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_cnt_q  <= '0;
            last_isi_q <= '0;
        end else begin
            isi_cnt_q  <= isi_cnt_d;
            last_isi_q <= last_isi_d;
        end
    end

    assign last_isi = last_isi_q;
`endif

endmodule
